// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared types and encodings for the data-memory access controller
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] MR_WORD  = 3'b111;
  localparam logic [2:0] MR_BYTE  = 3'b000;
  localparam logic [2:0] MR_BYTEU = 3'b100;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_BYTE = 4'b0001;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - byte-lane select and sign/zero extension of load data
import data_mem_ctrl_pkg::*;

module load_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            size,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0] lane;

  always_comb begin
    lane = rdata[{offset, 3'b000} +: 8];
    // Anything other than the two byte codes is a word load.
    if (size == MR_BYTE)
      data = {{(DATA_WIDTH-8){lane[7]}}, lane};
    else if (size == MR_BYTEU)
      data = {{(DATA_WIDTH-8){1'b0}}, lane};
    else
      data = rdata;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle data-memory access controller; optional misaligned-word trap via DATA_MEM_CTRL_MISALIGN_TRAP_EN
import data_mem_ctrl_pkg::*;

module data_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            MemWrite,
  input  logic [2:0]            MemRead,
  input  logic                  LoadEn,
  input  logic [DATA_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Stall,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic                  is_store;
  logic [1:0]            off_q;
  logic [2:0]            size_q;
  logic [7:0]            cnt;
  logic                  store_req;
  logic                  access;
  logic                  byte_acc;
  logic [DATA_WIDTH-1:0] load_data;

  assign store_req = (MemWrite != 4'b0000);
  assign access    = store_req | LoadEn;
  // A store takes precedence over a simultaneous load.
  assign byte_acc  = store_req ? (MemWrite == BE_BYTE)
                               : (MemRead == MR_BYTE || MemRead == MR_BYTEU);

  assign Stall = !rst && ((state == S_IDLE && access) || state == S_REQ || state == S_WAIT);

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .size   (size_q),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      is_store  <= 1'b0;
      off_q     <= 2'b00;
      size_q    <= 3'b000;
      cnt       <= 8'd0;
      Done      <= 1'b0;
      Fault     <= 1'b0;
      ReadData  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      Done     <= 1'b0;
      Fault    <= 1'b0;
      ReadData <= '0;
      case (state)
        S_IDLE: if (access) begin
          off_q    <= Addr[1:0];
          size_q   <= MemRead;
          is_store <= store_req;
`ifdef DATA_MEM_CTRL_MISALIGN_TRAP_EN
          if (!byte_acc && Addr[1:0] != 2'b00) begin
            state <= S_DONE;
            Done  <= 1'b1;
            Fault <= 1'b1;
          end else begin
`else
          begin
`endif
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_we   <= store_req;
            mem_addr <= {Addr[DATA_WIDTH-1:2], 2'b00};
            mem_be   <= byte_acc ? (BE_BYTE << Addr[1:0]) : BE_WORD;
            if (!store_req)
              mem_wdata <= '0;
            else if (byte_acc)
              mem_wdata <= {(DATA_WIDTH/8){WriteData[7:0]}};
            else
              mem_wdata <= WriteData;
          end
        end
        S_REQ: if (mem_ready) begin
          mem_req <= 1'b0;
          if (is_store) begin
            state <= S_DONE;
            Done  <= 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= 8'd0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state    <= S_DONE;
            Done     <= 1'b1;
            ReadData <= load_data;
          end else if (cnt == CNT_LAST) begin
            state <= S_DONE;
            Done  <= 1'b1;
            Fault <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - table-driven scoreboard bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  MemWrite;
  logic [2:0]  MemRead;
  logic        LoadEn;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        Stall;
  logic        Done;
  logic [31:0] ReadData;
  logic        Fault;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  data_mem_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .LoadEn     (LoadEn),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .Stall      (Stall),
    .Done       (Done),
    .ReadData   (ReadData),
    .Fault      (Fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mw;
    logic [2:0]  mr;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wd;
    int          rdy;
    int          rv;
    logic        nev;
    logic [31:0] rdata;
    logic        ereq;
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        efault;
    int          ecyc;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        f;
    int          cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] mw, input logic [2:0] mr, input logic ld,
                              input logic [31:0] addr, input logic [31:0] wd, input int rdy,
                              input int rv, input logic nev, input logic [31:0] rdata,
                              input logic ereq, input logic ewe, input logic [3:0] ebe,
                              input logic [31:0] eaddr, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic efault, input int ecyc);
    vec_t v;
    v.mw = mw; v.mr = mr; v.ld = ld; v.addr = addr; v.wd = wd;
    v.rdy = rdy; v.rv = rv; v.nev = nev; v.rdata = rdata;
    v.ereq = ereq; v.ewe = ewe; v.ebe = ebe; v.eaddr = eaddr; v.ewd = ewd;
    v.erd = erd; v.efault = efault; v.ecyc = ecyc;
    return v;
  endfunction

  task automatic clear_inputs();
    MemWrite  = 4'b0000;
    MemRead   = 3'b000;
    LoadEn    = 1'b0;
    Addr      = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic run(input vec_t v);
    int   cyc, rcnt, wcnt, stalls;
    bit   in_wait, req_seen, done;
    exp_t e;
    e.rd = v.erd; e.f = v.efault; e.cyc = v.ecyc;
    sbq.push_back(e);
    cyc = 0; rcnt = 0; wcnt = 0; stalls = 0;
    in_wait = 0; req_seen = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (cyc == 0) begin
        MemWrite = v.mw; MemRead = v.mr; LoadEn = v.ld; Addr = v.addr; WriteData = v.wd;
      end else begin
        clear_inputs();
      end
      if (Done) begin
        done = 1;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard_empty: got Done expected no completion");
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("read_data", ReadData, e.rd);
          chk("fault", {31'b0, Fault}, {31'b0, e.f});
        end
        chk("stall_cycles", stalls, v.ecyc);
        chk("stall_at_done", {31'b0, Stall}, 32'h0);
        chk("req_issued", {31'b0, req_seen}, {31'b0, v.ereq});
      end else begin
        if (mem_req) begin
          if (!req_seen) begin
            chk("mem_addr", mem_addr, v.eaddr);
            chk("mem_we", {31'b0, mem_we}, {31'b0, v.ewe});
            if (v.ewe) begin
              chk("mem_be", {28'b0, mem_be}, {28'b0, v.ebe});
              chk("mem_wdata", mem_wdata, v.ewd);
            end
          end
          req_seen = 1;
          mem_ready = (rcnt >= v.rdy);
          rcnt++;
        end else begin
          mem_ready = 1'b0;
        end
        mem_rvalid = in_wait && !v.nev && (wcnt >= v.rv);
        if (in_wait) wcnt++;
        mem_rdata = v.rdata;
        #1;
        if (Stall) stalls++;
        if (mem_req && mem_ready && !mem_we) in_wait = 1;
        cyc++;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL txn_timeout: got no Done within %0d cycles expected Done", cyc);
      void'(sbq.pop_back());
    end
  endtask

  initial begin
    int done_cnt;

    //        mw       mr      ld  addr          wd            rdy rv nev rdata         req we be       eaddr         ewd           erd           flt cyc
    tbl.push_back(mk(4'hF, 3'b000, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h0,        1, 1, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2));
    tbl.push_back(mk(4'h1, 3'b000, 0, 32'h203, 32'h000000A5, 0, 0, 0, 32'h0,        1, 1, 4'b1000, 32'h200, 32'hA5A5A5A5, 32'h0,        0, 2));
    tbl.push_back(mk(4'h1, 3'b000, 0, 32'h201, 32'h12345677, 2, 0, 0, 32'h0,        1, 1, 4'b0010, 32'h200, 32'h77777777, 32'h0,        0, 4));
    tbl.push_back(mk(4'h0, 3'b000, 1, 32'h001, 32'h0,        0, 3, 0, 32'h0000F000, 1, 0, 4'b0000, 32'h000, 32'h0,        32'hFFFFFFF0, 0, 6));
    tbl.push_back(mk(4'h0, 3'b100, 1, 32'h001, 32'h0,        0, 3, 0, 32'h0000F000, 1, 0, 4'b0000, 32'h000, 32'h0,        32'h000000F0, 0, 6));
    tbl.push_back(mk(4'h0, 3'b111, 1, 32'h040, 32'h0,        1, 0, 0, 32'h12345678, 1, 0, 4'b0000, 32'h040, 32'h0,        32'h12345678, 0, 4));
    tbl.push_back(mk(4'h0, 3'b111, 1, 32'h080, 32'h0,        0, 0, 1, 32'hFFFFFFFF, 1, 0, 4'b0000, 32'h080, 32'h0,        32'h0,        1, 6));
    tbl.push_back(mk(4'hF, 3'b000, 1, 32'h300, 32'hCAFEF00D, 0, 0, 0, 32'h0,        1, 1, 4'b1111, 32'h300, 32'hCAFEF00D, 32'h0,        0, 2));
    tbl.push_back(mk(4'h0, 3'b000, 1, 32'h003, 32'h0,        0, 0, 0, 32'h7F000000, 1, 0, 4'b0000, 32'h000, 32'h0,        32'h0000007F, 0, 3));
    tbl.push_back(mk(4'h0, 3'b010, 1, 32'h008, 32'h0,        0, 0, 0, 32'h80000001, 1, 0, 4'b0000, 32'h008, 32'h0,        32'h80000001, 0, 3));
`ifdef DATA_MEM_CTRL_MISALIGN_TRAP_EN
    tbl.push_back(mk(4'h0, 3'b111, 1, 32'h102, 32'h0,        0, 0, 0, 32'hAABBCCDD, 0, 0, 4'b0000, 32'h000, 32'h0,        32'h0,        1, 1));
    tbl.push_back(mk(4'hF, 3'b000, 0, 32'h105, 32'h11223344, 0, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h000, 32'h0,        32'h0,        1, 1));
`else
    tbl.push_back(mk(4'h0, 3'b111, 1, 32'h102, 32'h0,        0, 0, 0, 32'hAABBCCDD, 1, 0, 4'b0000, 32'h100, 32'h0,        32'hAABBCCDD, 0, 3));
    tbl.push_back(mk(4'hF, 3'b000, 0, 32'h105, 32'h11223344, 0, 0, 0, 32'h0,        1, 1, 4'b1111, 32'h104, 32'h11223344, 32'h0,        0, 2));
`endif

    rst = 1'b1;
    clear_inputs();
    LoadEn = 1'b1;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_done", {31'b0, Done}, 32'h0);
    chk("rst_read_data", ReadData, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    LoadEn = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outputs", {Stall, Done, Fault, mem_req, mem_we, mem_be}, 32'h0);
    chk("post_rst_addr", mem_addr | mem_wdata | ReadData, 32'h0);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Reset while waiting on read data: no completion, and stray rvalid afterwards is ignored.
    @(negedge clk);
    LoadEn = 1'b1; MemRead = 3'b111; Addr = 32'h10;
    @(negedge clk);
    clear_inputs();
    chk("rst_seq_req", {31'b0, mem_req}, 32'h1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_seq_wait_stall", {31'b0, Stall}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_seq_outputs", {Stall, Done, Fault, mem_req}, 32'h0);
    chk("rst_seq_read_data", ReadData, 32'h0);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h55555555;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) mem_rvalid = 1'b0;
      if (Done) done_cnt++;
    end
    chk("rst_seq_no_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory access controller between the CPU execute/memory stage and a variable-latency data memory. Takes the store byte-mask, load-size code, address and store data produced by the decoder/ALU. Runs a ready/valid transaction on the memory port and stalls the pipeline until the access completes. Aligns store bytes and extracts/extends load bytes.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a load is aborted; range 1–255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- MemWrite  in  4  store byte mask from decode: 1111 = word, 0001 = byte, 0000 = no store.
- MemRead  in  3  load size: 111 = word, 000 = byte sign-extended, 100 = byte zero-extended.
- LoadEn  in  1  a load is present this cycle.
- Addr  in  DATA_WIDTH  byte address (ALU result).
- WriteData  in  DATA_WIDTH  store data (rs2).
- Stall  out  1  hold the pipeline.
- Done  out  1  one-cycle completion pulse.
- ReadData  out  DATA_WIDTH  aligned and extended load result, valid while Done = 1.
- Fault  out  1  one-cycle pulse with Done on timeout or trapped misalignment.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables.
- mem_addr  out  DATA_WIDTH  word address; bits [1:0] are always 0.
- mem_wdata  out  DATA_WIDTH  write data, byte-lane aligned.
- mem_ready  in  1  memory accepts the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_WIDTH  read data.

## Operation
- States are IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Every output is 0 during and immediately after reset, including ReadData.
- Access present = (MemWrite != 0) | LoadEn. If both are set, the store wins and the load is ignored.
- IDLE:
  - Stall = access present (combinational).
  - If an access is present, latch addr, mask, size, data and the load/store flag, then go to REQ.
- REQ:
  - mem_req = 1, with mem_we, mem_be, mem_addr and mem_wdata driven from registers and held stable until mem_ready.
  - On mem_ready, a store goes to DONE and a load goes to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On mem_rvalid, capture the aligned load data and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES without mem_rvalid, set ReadData = 0, arm Fault and go to DONE.
- DONE:
  - Stall = 0, Done = 1, and Fault = 1 if armed.
  - Inputs are ignored. Next state is IDLE.
- Byte store: mem_be = 0001 << Addr[1:0]; mem_wdata = WriteData[7:0] replicated into all four lanes.
- Word store: mem_be = 1111; mem_wdata = WriteData.
- Loads:
  - Byte: select byte Addr[1:0] of mem_rdata, then sign-extend (000) or zero-extend (100).
  - Word: pass mem_rdata through.
- Undefined MemRead codes are treated as word.
- mem_rvalid outside WAIT is ignored.
- Reset mid-transaction: IDLE on the next edge, with mem_req low from that edge. No completion pulse.

## Timing
- Store with mem_ready in the first REQ cycle:
  - Request at cycle 0, REQ at cycle 1, DONE at cycle 2.
  - Stall is high in cycles 0–1.
- Load with mem_ready at 1 and mem_rvalid at 2: DONE at cycle 3; Stall is high for 3 cycles.
- Each cycle without mem_ready or mem_rvalid adds one stall cycle.
- Back-to-back accesses: a new request may be accepted in the IDLE cycle right after DONE. The minimum period is 3 cycles for stores and 4 for loads.
- Counter width is 8 bits; it clears on entry to WAIT.

## Configuration
- The macro DATA_MEM_CTRL_MISALIGN_TRAP_EN controls misaligned word accesses (word access with Addr[1:0] != 0).
- Defined:
  - No memory request is issued.
  - The FSM goes IDLE→DONE with Fault = 1 and ReadData = 0; the store is dropped.
- Undefined:
  - Addr[1:0] are ignored for word accesses and the aligned word is accessed.
  - Fault then signals timeout only.

## Structure
- Package data_mem_ctrl_pkg holds:
  - the state enum;
  - the MemRead encodings (MR_WORD = 111, MR_BYTE = 000, MR_BYTEU = 100);
  - the byte-enable constants (BE_WORD, BE_BYTE).
- Sub-module load_align: combinational byte select and sign/zero extension from mem_rdata, Addr[1:0] and size.

## Test plan
- Word store, Addr 0x100, data 0xDEADBEEF, mem_ready held 1 → mem_be = 1111, mem_addr = 0x100; Done at cycle 2; Stall high for 2 cycles.
- Byte store, Addr 0x203, data 0x000000A5 → mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x200.
- Byte load with MemRead 000 and 100, Addr 0x1, mem_rdata 0x0000F000 with rvalid delayed 3 cycles → ReadData 0xFFFFFFF0 and 0x000000F0 respectively; Stall held until DONE.
- Load with mem_rvalid never asserted, TIMEOUT_CYCLES = 4 → Fault and Done pulse together after 4 WAIT cycles; ReadData = 0.
- rst asserted while in WAIT → IDLE on the next edge, all outputs 0, no Done pulse. A simultaneous LoadEn + MemWrite = 1111 performs the store only.
- Word load at Addr 0x102 → with DATA_MEM_CTRL_MISALIGN_TRAP_EN: Fault at cycle 1 and no mem_req. Without it: mem_addr = 0x100 and a normal access.
